// File: rtl/mod_reduce_unit.sv
// mod_reduce_unit: bit-serial reduction of a signed XW-bit operand modulo an unsigned MW-bit modulus.
// Optional build macro MODRED_CENTERED_EN returns the centered representative instead of [0, m).
module mod_reduce_unit #(
  parameter int XW = 26,
  parameter int MW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] x,
  input  logic [MW-1:0] m,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [MW:0]   r
);
  localparam int CW = $clog2(XW);
  typedef enum logic [2:0] {IDLE, LOAD, DIV, FIX, DONE} state_t;
  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] absx_q, absx_d;
  logic [MW-1:0] m_q, m_d;
  logic          sign_q, sign_d;
  logic [MW:0]   rem_q, rem_d;
  logic [MW:0]   r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [MW+1:0] t;
  logic [MW:0]   sub;
  logic [MW:0]   fixed;
  logic [MW:0]   res;
`ifdef MODRED_CENTERED_EN
  logic [MW-1:0] half;
`endif
  // Restoring step operands, sign fix-up of the remainder and the value loaded into r on DONE entry
  always_comb begin
    t = {rem_q, absx_q[XW-1]};
    sub = t[MW:0] - {1'b0, m_q};
    fixed = (sign_q && rem_q != '0) ? {1'b0, m_q} - rem_q : rem_q;
`ifdef MODRED_CENTERED_EN
    half = (m_q - MW'(1)) >> 1;
    res = (fixed > {1'b0, half}) ? fixed - {1'b0, m_q} : fixed;
`else
    res = fixed;
`endif
  end
  // Next-state logic: operands are captured on acceptance so the requester may change them afterwards
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    absx_d = absx_q;
    m_d = m_q;
    sign_d = sign_q;
    rem_d = rem_q;
    r_d = r_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          x_d = x;
          m_d = m;
          busy_d = 1'b1;
          err_d = 1'b0;
        end
      end
      LOAD: begin
        sign_d = x_q[XW-1];
        absx_d = x_q[XW-1] ? -x_q : x_q;
        rem_d = '0;
        cnt_d = '0;
        state_d = (m_q == '0) ? DONE : DIV;
        done_d = (m_q == '0);
        err_d = (m_q == '0);
        r_d = (m_q == '0) ? '0 : r_q;
      end
      DIV: begin
        rem_d = (t >= {2'b00, m_q}) ? sub : t[MW:0];
        absx_d = absx_q << 1;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(XW - 1)) ? FIX : DIV;
      end
      FIX: begin
        rem_d = fixed;
        r_d = res;
        done_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  // State and registered outputs; synchronous active-low reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      absx_q <= '0;
      m_q <= '0;
      sign_q <= 1'b0;
      rem_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      absx_q <= absx_d;
      m_q <= m_d;
      sign_q <= sign_d;
      rem_q <= rem_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign r = r_q;
endmodule
